// File: rtl/ucpu_pkg.sv
// ucpu_pkg
// Shared definitions for the ALU sequencer: opcode and FSM state enums,
// default ALU register-select codes, instruction field offsets and a small
// opcode classification helper. No ports.
package ucpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_OR    = 4'd3,
        OP_AND   = 4'd4,
        OP_NOT   = 4'd5,
        OP_LSL   = 4'd6,
        OP_LSR   = 4'd7,
        OP_ASR   = 4'd8,
        OP_CMP   = 4'd9,
        OP_ILL_A = 4'd10,
        OP_ILL_B = 4'd11,
        OP_ILL_C = 4'd12,
        OP_ILL_D = 4'd13,
        OP_ILL_E = 4'd14,
        OP_LDI   = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    localparam int A_REG_MAP_DEF = 16;
    localparam int B_REG_MAP_DEF = 17;

    // Instruction field offsets (LSB of each field)
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;

    // Opcodes 1010..1110 have no defined behaviour
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd10) && (op != 4'd15);
    endfunction

endpackage

// File: rtl/ucpu_alu_sequencer_if.sv
// ucpu_alu_sequencer_if
// Fetch-to-sequencer instruction handshake.
//   instr_valid : fetch has an instruction on instr
//   instr_ready : sequencer can accept
//   instr       : 16-bit instruction word
// Handshake: a transfer happens on a rising clock edge where instr_valid and
// instr_ready are both 1. While instr_valid is 1 and instr_ready is 0 the
// master must hold instr stable and keep instr_valid asserted. instr_ready
// does not depend on instr_valid.
// Modports: master (fetch side), slave (sequencer side).
interface ucpu_alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/ucpu_regfile.sv
// ucpu_regfile
// Register file for the sequencer. R0 reads as zero and ignores writes.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset (clears all)
//   raddr_a/rdata_a       : combinational read port A
//   raddr_b/rdata_b       : combinational read port B
//   dbg_raddr/dbg_rdata   : combinational debug read port
//   we/waddr/wdata        : synchronous write port
module ucpu_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] raddr_a,
    input  logic [IDX_W-1:0] raddr_b,
    input  logic [IDX_W-1:0] dbg_raddr,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] dbg_rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/ucpu_alu_sequencer.sv
// ucpu_alu_sequencer
// Accepts register-register instructions from fetch, loads the ALU A/B
// operand registers from the internal register file, issues the opcode and
// writes the ALU result back (or latches compare flags for cmp).
// Ports:
//   sysclk, rst_n           : clock, asynchronous active-low reset
//   fetch (slave modport)   : instr_valid / instr_ready / instr
//   A_bus, B_bus, reg_src,
//   alu_en, alu_op          : ALU operand load and opcode outputs
//   alu_result, cc_greater,
//   cc_equal                : combinational ALU outputs
//   flag_gt, flag_eq        : latched compare flags
//   retire, illegal_op      : one-cycle completion / undefined-opcode pulses
//   dbg_raddr, dbg_rdata    : debug register read
//   dbg_state               : current FSM state
// Build option: UCPU_SEQ_UNARY_SKIP_EN lets `not` skip the B operand load.
module ucpu_alu_sequencer
    import ucpu_pkg::*;
#(
    parameter int ALU_WIDTH = 8,
    parameter int ALU_OPS   = 16,
    parameter int NUM_REGS  = 16,
    parameter int A_REG_MAP = A_REG_MAP_DEF,
    parameter int B_REG_MAP = B_REG_MAP_DEF
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    ucpu_alu_sequencer_if.slave        fetch,
    output logic [ALU_WIDTH-1:0]       A_bus,
    output logic [ALU_WIDTH-1:0]       B_bus,
    output logic                       alu_en,
    output logic [4:0]                 reg_src,
    output logic [$clog2(ALU_OPS)-1:0] alu_op,
    input  logic [ALU_WIDTH-1:0]       alu_result,
    input  logic                       cc_greater,
    input  logic                       cc_equal,
    output logic                       flag_gt,
    output logic                       flag_eq,
    output logic                       retire,
    output logic                       illegal_op,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_raddr,
    output logic [ALU_WIDTH-1:0]       dbg_rdata,
    output state_t                     dbg_state
);

    localparam int OP_W  = $clog2(ALU_OPS);
    localparam int IDX_W = $clog2(NUM_REGS);

    state_t           state, next_state;
    logic [15:0]      instr_q;
    opcode_t          in_op, q_op;
    logic [ALU_WIDTH-1:0] rdata_a, rdata_b, wr_data;
    logic             wr_en, flag_load, retire_d, illegal_d;

    assign in_op = opcode_t'(fetch.instr[OP_LSB +: 4]);
    assign q_op  = opcode_t'(instr_q[OP_LSB +: 4]);

    assign fetch.instr_ready = (state == ST_IDLE);
    assign dbg_state         = state;

    ucpu_regfile #(
        .WIDTH (ALU_WIDTH),
        .DEPTH (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk       (sysclk),
        .rst_n     (rst_n),
        .raddr_a   (instr_q[RS1_LSB +: IDX_W]),
        .raddr_b   (instr_q[RS2_LSB +: IDX_W]),
        .dbg_raddr (dbg_raddr),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .dbg_rdata (dbg_rdata),
        .we        (wr_en),
        .waddr     (instr_q[RD_LSB +: IDX_W]),
        .wdata     (wr_data)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            instr_q    <= '0;
            flag_gt    <= 1'b0;
            flag_eq    <= 1'b0;
            retire     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= next_state;
            retire     <= retire_d;
            illegal_op <= illegal_d;
            if ((state == ST_IDLE) && fetch.instr_valid) begin
                instr_q <= fetch.instr;
            end
            if (flag_load) begin
                flag_gt <= cc_greater;
                flag_eq <= cc_equal;
            end
        end
    end

    always_comb begin
        next_state = state;
        A_bus      = '0;
        B_bus      = '0;
        reg_src    = '0;
        alu_en     = 1'b0;
        alu_op     = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        flag_load  = 1'b0;
        retire_d   = 1'b0;
        illegal_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch.instr_valid) begin
                    if (in_op == OP_NOP) begin
                        retire_d = 1'b1;
                    end else if (is_illegal(in_op)) begin
                        illegal_d = 1'b1;
                    end else if (in_op == OP_LDI) begin
                        next_state = ST_EXEC;
                    end else begin
                        next_state = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                A_bus   = rdata_a;
                reg_src = 5'(A_REG_MAP);
                alu_en  = 1'b1;
`ifdef UCPU_SEQ_UNARY_SKIP_EN
                // Unary not only needs A; B keeps whatever it held
                next_state = (q_op == OP_NOT) ? ST_EXEC : ST_LOAD_B;
`else
                next_state = ST_LOAD_B;
`endif
            end
            ST_LOAD_B: begin
                B_bus      = rdata_b;
                reg_src    = 5'(B_REG_MAP);
                alu_en     = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op     = (q_op == OP_LDI) ? '0 : OP_W'(q_op);
                retire_d   = 1'b1;
                next_state = ST_IDLE;
                if (q_op == OP_CMP) begin
                    flag_load = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = (q_op == OP_LDI) ? ALU_WIDTH'(instr_q[IMM_LSB +: 8]) : alu_result;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ucpu_alu_sequencer.sv
// tb_ucpu_alu_sequencer
// Bench for ucpu_alu_sequencer: directed scenarios followed by random
// instruction streams, checked against an instruction-level reference model.
module tb_ucpu_alu_sequencer;

`ifdef UCPU_SEQ_UNARY_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    // ---------------- DUT ----------------
    ucpu_alu_sequencer_if fetch_if();
    logic [7:0]  A_bus, B_bus, alu_result, dbg_rdata;
    logic        alu_en, cc_greater, cc_equal, flag_gt, flag_eq, retire, illegal_op;
    logic [4:0]  reg_src;
    logic [3:0]  alu_op;
    logic [3:0]  dbg_raddr;
    ucpu_pkg::state_t dbg_state;

    ucpu_alu_sequencer dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .fetch      (fetch_if),
        .A_bus      (A_bus),
        .B_bus      (B_bus),
        .alu_en     (alu_en),
        .reg_src    (reg_src),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .cc_greater (cc_greater),
        .cc_equal   (cc_equal),
        .flag_gt    (flag_gt),
        .flag_eq    (flag_eq),
        .retire     (retire),
        .illegal_op (illegal_op),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- ALU behaviour shared by environment and model ----------------
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return ~a;
            4'd6:    return a << 1;
            4'd7:    return a >> 1;
            4'd8:    return {a[7], a[7:1]};
            4'd9:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    // Downstream ALU: operand registers loaded by reg_src code
    logic [7:0] alu_a = 8'h00;
    logic [7:0] alu_b = 8'h00;
    always @(posedge sysclk) begin
        if (alu_en && reg_src == 5'd16) alu_a <= A_bus;
        if (alu_en && reg_src == 5'd17) alu_b <= B_bus;
    end
    assign alu_result = alu_fn(alu_op, alu_a, alu_b);
    assign cc_greater = (alu_a > alu_b);
    assign cc_equal   = (alu_a == alu_b);

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [20:0] exp_q[$];   // {reg_src, A_bus, B_bus} per operand load
    logic [3:0]  op_q[$];    // alu_op per execute cycle
    logic [7:0]  ref_regs [16];
    logic        ref_gt, ref_eq;
    int exp_retire = 0, exp_illegal = 0;
    int obs_retire = 0, obs_illegal = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        ref_gt = 1'b0;
        ref_eq = 1'b0;
    endtask

    // Instruction-level model: expected busy cycles, pulses, bus traffic, state update
    task automatic model(input logic [15:0] ins, output int lat, output logic ret, output logic ill);
        logic [3:0] op, rd;
        logic [7:0] a, b;
        op  = ins[15:12];
        rd  = ins[11:8];
        a   = ref_regs[ins[7:4]];
        b   = ref_regs[ins[3:0]];
        ret = 1'b1;
        ill = 1'b0;
        lat = 3;
        if (op == 4'd0) begin
            lat = 0;
        end else if (op == 4'd15) begin
            lat = 1;
            op_q.push_back(4'd0);
            if (rd != 4'd0) ref_regs[rd] = ins[7:0];
        end else if (op >= 4'd10) begin
            lat = 0; ret = 1'b0; ill = 1'b1;
        end else begin
            exp_q.push_back({5'd16, a, 8'h00});
            if (op == 4'd5 && SKIP) lat = 2;
            else exp_q.push_back({5'd17, 8'h00, b});
            op_q.push_back(op);
            if (op == 4'd9) begin
                ref_gt = (a > b);
                ref_eq = (a == b);
            end else if (rd != 4'd0) begin
                ref_regs[rd] = alu_fn(op, a, b);
            end
        end
        exp_retire  += int'(ret);
        exp_illegal += int'(ill);
    endtask

    // Bus monitor, sampled on the falling edge
    always @(negedge sysclk) begin
        if (rst_n) begin
            if (retire) obs_retire++;
            if (illegal_op) obs_illegal++;
            if (alu_en) begin
                check("load_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("bus_load", {reg_src, A_bus, B_bus}, exp_q.pop_front());
                check("op_in_load", alu_op, 4'd0);
            end else if (!fetch_if.instr_ready) begin
                check("exec_pending", 32'(op_q.size() > 0), 32'd1);
                if (op_q.size() > 0) check("exec_op", alu_op, op_q.pop_front());
                check("bus_in_exec", {reg_src, A_bus, B_bus}, 21'd0);
            end else begin
                check("bus_idle", {alu_op, reg_src, A_bus, B_bus}, 25'd0);
            end
        end
    end

    // ---------------- driver ----------------
    // Entered and left on a falling edge; instr_valid stays high on return
    task automatic send(input logic [15:0] ins);
        int   lat, busy;
        logic ret, ill;
        model(ins, lat, ret, ill);
        fetch_if.instr_valid = 1'b1;
        fetch_if.instr       = ins;
        check("ready_before", fetch_if.instr_ready, 1'b1);
        @(posedge sysclk);
        @(negedge sysclk);
        busy = 0;
        while (!fetch_if.instr_ready && busy < 10) begin
            check("retire_busy", retire, 1'b0);
            busy++;
            @(negedge sysclk);
        end
        check("latency", busy, lat);
        check("retire", retire, ret);
        check("illegal", illegal_op, ill);
        check("flag_gt", flag_gt, ref_gt);
        check("flag_eq", flag_eq, ref_eq);
        dbg_raddr = ins[11:8];
        #1;
        check("rd_value", dbg_rdata, ref_regs[ins[11:8]]);
    endtask

    task automatic idle(input int cycles);
        fetch_if.instr_valid = 1'b0;
        repeat (cycles) @(negedge sysclk);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_raddr = 4'(i);
            #1;
            check(tag, dbg_rdata, ref_regs[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ret_before;
        logic [15:0] ins;
        fetch_if.instr_valid = 1'b0;
        fetch_if.instr       = 16'h0000;
        dbg_raddr            = 4'd3;
        ref_reset();
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);

        // reset state
        check("rst_dbg_r3", dbg_rdata, 8'h00);
        check("rst_ready", fetch_if.instr_ready, 1'b1);
        check("rst_outs", {A_bus, B_bus, reg_src, alu_en, alu_op, flag_gt, flag_eq, retire, illegal_op}, 30'd0);

        // back-to-back dependent sequence
        send(16'hF12A);
        send(16'hF205);
        send(16'h1312);
        idle(1);
        // compare then sub: flags held
        send(16'h9012);
        send(16'h2612);
        idle(1);
        // illegal opcode, write to R0
        send(16'hB123);
        send(16'hF0FF);
        idle(1);
        // unary not
        send(16'h5510);
        idle(2);
        check_all_regs("dir_regs");

        // reset during LOAD_B of add R4,R1,R2
        ret_before = obs_retire;
        exp_q.push_back({5'd16, ref_regs[1], 8'h00});
        exp_q.push_back({5'd17, 8'h00, ref_regs[2]});
        fetch_if.instr_valid = 1'b1;
        fetch_if.instr       = 16'h1412;
        @(posedge sysclk);
        #1 fetch_if.instr_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        ref_reset();
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
        check("abort_ready", fetch_if.instr_ready, 1'b1);
        check("abort_retire", obs_retire, ret_before);
        check("abort_loads_done", exp_q.size(), 0);
        check_all_regs("abort_regs");

        // random stream
        for (int n = 0; n < 300; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'd15;
            send(ins);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check_all_regs("rand_regs");
        check("retire_total", obs_retire, exp_retire);
        check("illegal_total", obs_illegal, exp_illegal);
        check("loads_drained", exp_q.size(), 0);
        check("execs_drained", op_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
